// File: rtl/perm_unload.sv
// ============================================================================
// Module   : perm_unload
// Brief    : Captures a permuted 1600-bit Keccak state and unloads it as
//            eight 200-bit beats in ascending chunk order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module perm_unload #(
    parameter int CHUNK_W = 200,
    parameter int NCHUNK  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHUNK_W*NCHUNK-1:0] state_in,
    input  logic                      loadin,
    output logic                      readyout,
    input  logic                      stopin,
    output logic [2:0]                doutix,
    output logic [CHUNK_W-1:0]        dout,
    output logic                      pushout,
    output logic                      ovf_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [2:0] C_LAST_IX = 3'd7;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CHUNK_W*NCHUNK-1:0]   r_shadow;
    logic [2:0]                  r_cnt;
    logic [2:0]                  r_doutix;
    logic [CHUNK_W-1:0]          r_dout;
    logic                        r_pushout;
    logic                        r_ovf_err;

    logic                        w_last;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_beat;
    logic [CHUNK_W-1:0]          w_chunk [NCHUNK];

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        assign w_chunk[g] = r_shadow[g*CHUNK_W +: CHUNK_W];
    end

    // A new load may only land on the edge that issues the final beat, so the
    // shadow is never overwritten while unsent chunks remain.
    assign w_last   = (r_cnt == C_LAST_IX);
    assign w_ready  = (r_state == ST_IDLE) || ((r_state == ST_SEND) && w_last && !stopin);
    assign w_accept = loadin && w_ready;
    assign w_beat   = (r_state == ST_SEND) && !stopin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                end else if (w_beat && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Beat data is taken from the old shadow before a same-edge load replaces it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow  <= '0;
            r_cnt     <= 3'd0;
            r_doutix  <= 3'd0;
            r_dout    <= '0;
            r_pushout <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_pushout <= w_beat;
            if (w_beat) begin
                r_doutix <= r_cnt;
                r_dout   <= w_chunk[r_cnt];
                r_cnt    <= r_cnt + 3'd1;
            end
            if (w_accept) begin
                r_shadow <= state_in;
                r_cnt    <= 3'd0;
            end
            if (loadin && !w_ready) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign readyout = w_ready;
    assign doutix   = r_doutix;
    assign dout     = r_dout;
    assign pushout  = r_pushout;
    assign ovf_err  = r_ovf_err;

endmodule

`default_nettype wire

// File: tb/tb_perm_unload.sv
// ============================================================================
// Module   : tb_perm_unload
// Brief    : Scoreboard bench for perm_unload with a beats-remaining model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_perm_unload;

    typedef struct {
        logic [2:0]   idx;
        logic [199:0] data;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [1599:0] state_in;
    logic          loadin;
    logic          readyout;
    logic          stopin;
    logic [2:0]    doutix;
    logic [199:0]  dout;
    logic          pushout;
    logic          ovf_err;

    int            checks;
    int            errors;
    beat_t         exp_q[$];
    beat_t         last_beat;
    int            remaining;
    logic          exp_ovf;
    logic          mon_en;

    perm_unload #(
        .CHUNK_W (200),
        .NCHUNK  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .state_in (state_in),
        .loadin   (loadin),
        .readyout (readyout),
        .stopin   (stopin),
        .doutix   (doutix),
        .dout     (dout),
        .pushout  (pushout),
        .ovf_err  (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int w = 0; w < 50; w++) s[w*32 +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [1599:0] fill_state(input logic [7:0] b);
        logic [1599:0] s;
        for (int i = 0; i < 200; i++) s[i*8 +: 8] = b;
        return s;
    endfunction

    function automatic logic [1599:0] ramp_state();
        logic [1599:0] s;
        logic [7:0]    b;
        for (int i = 0; i < 8; i++) begin
            b = 8'(i + 1);
            s[i*200 +: 200] = {25{b}};
        end
        return s;
    endfunction

    // Model: a loaded state owes 8 beats; one is paid on every unstalled edge.
    // A load is taken when nothing is owed, or when the last owed beat goes out now.
    task automatic step(input logic ld, input logic st, input logic [1599:0] s);
        logic  exp_ready;
        beat_t b;
        loadin    = ld;
        stopin    = st;
        state_in  = s;
        exp_ready = (remaining == 0) || (remaining == 1 && !st);
        @(negedge clk);
        chk("readyout", 200'(readyout), 200'(exp_ready));
        chk("ovf_err", 200'(ovf_err), 200'(exp_ovf));
        @(posedge clk);
        if (ld && !exp_ready) exp_ovf = 1'b1;
        if (remaining > 0 && !st) remaining--;
        if (ld && exp_ready) begin
            remaining = 8;
            for (int i = 0; i < 8; i++) begin
                b.idx  = 3'(i);
                b.data = s[i*200 +: 200];
                exp_q.push_back(b);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        remaining      = 0;
        exp_ovf        = 1'b0;
        last_beat.idx  = 3'd0;
        last_beat.data = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pushout"}, 200'(pushout), 200'(0));
        chk({tag, "_doutix"}, 200'(doutix), 200'(0));
        chk({tag, "_dout"}, dout, 200'(0));
        chk({tag, "_ovf_err"}, 200'(ovf_err), 200'(0));
        chk({tag, "_readyout"}, 200'(readyout), 200'(1));
    endtask

    // Monitor: every pushout beat must be the next queued beat; otherwise outputs hold.
    always @(negedge clk) begin
        beat_t b;
        if (reset && mon_en) begin
            if (pushout) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 200'(doutix), 200'(8));
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_ix", 200'(doutix), 200'(b.idx));
                    chk("beat_data", dout, b.data);
                    last_beat = b;
                end
            end else begin
                chk("hold_ix", 200'(doutix), 200'(last_beat.idx));
                chk("hold_data", dout, last_beat.data);
            end
        end
    end

    initial begin
        logic [1599:0] sa;
        logic [1599:0] sb;
        int            guard;
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        reset    = 1'b0;
        loadin   = 1'b0;
        stopin   = 1'b0;
        state_in = '0;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #3 reset = 1'b1;
        mon_en = 1'b1;

        // Single load of a ramp pattern
        step(1'b1, 1'b0, ramp_state());
        idle(10);

        // Stall after beat 2 for three cycles
        sa = rand_state();
        step(1'b1, 1'b0, sa);
        idle(3);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, '0);
        idle(7);

        // Back-to-back: load B on the edge that issues A's beat 7
        sa = fill_state(8'hAA);
        sb = fill_state(8'h55);
        step(1'b1, 1'b0, sa);
        idle(7);
        step(1'b1, 1'b0, sb);
        idle(10);

        // Overflow: load C while A is mid-transfer
        sa = rand_state();
        step(1'b1, 1'b0, sa);
        idle(2);
        step(1'b1, 1'b0, rand_state());
        idle(8);

        // Stall on the last beat with a load pending
        sa = rand_state();
        step(1'b1, 1'b0, sa);
        idle(7);
        step(1'b1, 1'b1, rand_state());
        idle(3);

        // Asynchronous reset after beat 4
        sa = rand_state();
        step(1'b1, 1'b0, sa);
        idle(5);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_model();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        idle(4);
        step(1'b1, 1'b0, ramp_state());
        idle(9);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), rand_state());
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            step(1'b0, 1'b0, '0);
            guard++;
        end
        idle(2);
        chk("drain_empty", 200'(exp_q.size()), 200'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
